// File: rtl/lshift_pkg.sv
// Shared types and default widths for the two-requester left-shift engine.
// Optional build macro: LSHIFT_BARREL_EN (single-cycle barrel shift instead of the iterative engine).
package lshift_pkg;

   localparam int DIN_W   = 4;
   localparam int SHAMT_W = 4;
   localparam int DOUT_W  = 16;

   localparam logic OWNER_A = 1'b0;
   localparam logic OWNER_B = 1'b1;

   typedef enum logic [1:0] {
      IDLE,
      SHIFT,
      DONE
   } state_t;

endpackage

// File: rtl/lshift_rr_arb.sv
// Two-way round-robin arbiter: a tie goes to the channel that did not win last time.
module lshift_rr_arb
   import lshift_pkg::*;
(
   input  logic       req_a,
   input  logic       req_b,
   input  logic       last_owner,
   input  logic       enable,
   output logic [1:0] gnt,
   output logic       owner
);

   // NOTE: every output gets a default first so this block never infers a latch.
   always_comb begin
      gnt   = 2'b00;
      owner = OWNER_A;
      if (enable) begin
         if (req_a && req_b) begin
            owner = (last_owner == OWNER_A) ? OWNER_B : OWNER_A;
         end else if (req_b) begin
            owner = OWNER_B;
         end else begin
            owner = OWNER_A;
         end
         if (req_a || req_b) begin
            gnt = (owner == OWNER_B) ? 2'b10 : 2'b01;
         end
      end
   end

endmodule

// File: rtl/lshift_arbiter.sv
// Shares one 16-bit left-shift engine between channels A and B with round-robin arbitration.
// Define LSHIFT_BARREL_EN to replace the one-bit-per-cycle engine with a single-cycle barrel shift.
module lshift_arbiter
   import lshift_pkg::*;
(
   input  logic               clk,
   input  logic               rst_n,
   input  logic               req_a,
   input  logic [DIN_W-1:0]   bit4_a,
   input  logic [SHAMT_W-1:0] shamt_a,
   output logic               gnt_a,
   input  logic               req_b,
   input  logic [DIN_W-1:0]   bit4_b,
   input  logic [SHAMT_W-1:0] shamt_b,
   output logic               gnt_b,
   output logic               res_valid,
   output logic [DOUT_W-1:0]  res_data,
   output logic               res_owner,
   input  logic               res_ready,
   output logic               busy
);

   state_t               state;
   logic                 last_owner;
   logic [1:0]           arb_gnt;
   logic                 arb_owner;
   logic [DIN_W-1:0]     sel_bit4;
   logic [SHAMT_W-1:0]   sel_shamt;
`ifndef LSHIFT_BARREL_EN
   logic [SHAMT_W-1:0]   count;
`endif

   lshift_rr_arb u_arb (
      .req_a      (req_a),
      .req_b      (req_b),
      .last_owner (last_owner),
      .enable     (state == IDLE),
      .gnt        (arb_gnt),
      .owner      (arb_owner)
   );

   assign sel_bit4  = (arb_owner == OWNER_B) ? bit4_b  : bit4_a;
   assign sel_shamt = (arb_owner == OWNER_B) ? shamt_b : shamt_a;
   assign busy      = (state != IDLE);

   // NOTE: all state is updated with non-blocking assignments; reset is sampled on the clock edge.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state      <= IDLE;
         gnt_a      <= 1'b0;
         gnt_b      <= 1'b0;
         res_valid  <= 1'b0;
         res_data   <= '0;
         res_owner  <= OWNER_A;
         last_owner <= OWNER_B;
`ifndef LSHIFT_BARREL_EN
         count      <= '0;
`endif
      end else begin
         gnt_a <= 1'b0;
         gnt_b <= 1'b0;
         case (state)
            IDLE: begin
               if (arb_gnt != 2'b00) begin
                  gnt_a      <= arb_gnt[0];
                  gnt_b      <= arb_gnt[1];
                  res_owner  <= arb_owner;
                  last_owner <= arb_owner;
`ifdef LSHIFT_BARREL_EN
                  res_data   <= DOUT_W'(sel_bit4) << sel_shamt;
                  state      <= DONE;
`else
                  res_data   <= DOUT_W'(sel_bit4);
                  count      <= sel_shamt;
                  state      <= (sel_shamt != '0) ? SHIFT : DONE;
`endif
               end
            end
`ifndef LSHIFT_BARREL_EN
            SHIFT: begin
               res_data <= res_data << 1;
               count    <= count - 1'b1;
               if (count == SHAMT_W'(1)) begin
                  state <= DONE;
               end
            end
`endif
            DONE: begin
               // res_valid rises one cycle after entering DONE and drops on the handshake.
               if (res_valid && res_ready) begin
                  res_valid <= 1'b0;
                  state     <= IDLE;
               end else begin
                  res_valid <= 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_lshift_arbiter.sv
// Self-checking bench for lshift_arbiter: directed scenarios plus random traffic against a transaction-level model.
// Build with LSHIFT_BARREL_EN defined to check the barrel-shift timing.
module tb_lshift_arbiter;
   import lshift_pkg::*;

   logic               clk = 1'b0;
   logic               rst_n;
   logic               req_a, req_b, res_ready;
   logic [DIN_W-1:0]   bit4_a, bit4_b;
   logic [SHAMT_W-1:0] shamt_a, shamt_b;
   logic               gnt_a, gnt_b, res_valid, res_owner, busy;
   logic [DOUT_W-1:0]  res_data;

   int n_cmp = 0;
   int n_bad = 0;

   // Model state: job in flight, due cycle for res_valid, expected result.
   bit m_idle, m_valid, m_gnt_a, m_gnt_b, m_owner, m_last;
   int m_data, m_due, m_cyc;

   lshift_arbiter dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req_a     (req_a),
      .bit4_a    (bit4_a),
      .shamt_a   (shamt_a),
      .gnt_a     (gnt_a),
      .req_b     (req_b),
      .bit4_b    (bit4_b),
      .shamt_b   (shamt_b),
      .gnt_b     (gnt_b),
      .res_valid (res_valid),
      .res_data  (res_data),
      .res_owner (res_owner),
      .res_ready (res_ready),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   function automatic int latency(input int sh);
`ifdef LSHIFT_BARREL_EN
      return 1;
`else
      return sh + 1;
`endif
   endfunction

   // One clock: update the model from the inputs applied before the edge, then compare at the falling edge.
   task automatic step();
      bit r_a, r_b, rdy, rst;
      int op_a, op_b, sh_a, sh_b, op, sh;
      r_a = req_a; r_b = req_b; rdy = res_ready; rst = rst_n;
      op_a = int'(bit4_a); op_b = int'(bit4_b);
      sh_a = int'(shamt_a); sh_b = int'(shamt_b);
      @(posedge clk);
      m_cyc++;
      m_gnt_a = 1'b0;
      m_gnt_b = 1'b0;
      if (!rst) begin
         m_idle = 1'b1; m_valid = 1'b0; m_owner = 1'b0; m_data = 0; m_last = 1'b1;
      end else if (m_idle) begin
         if (r_a || r_b) begin
            m_owner = (r_a && r_b) ? !m_last : r_b;
            m_last  = m_owner;
            m_gnt_a = !m_owner;
            m_gnt_b = m_owner;
            op      = m_owner ? op_b : op_a;
            sh      = m_owner ? sh_b : sh_a;
            m_data  = (op * (1 << sh)) % 65536;
            m_due   = m_cyc + latency(sh);
            m_idle  = 1'b0;
         end
      end else if (m_valid && rdy) begin
         m_valid = 1'b0;
         m_idle  = 1'b1;
      end else if (m_cyc >= m_due) begin
         m_valid = 1'b1;
      end
      @(negedge clk);
      check("gnt_a", gnt_a, m_gnt_a);
      check("gnt_b", gnt_b, m_gnt_b);
      check("res_valid", res_valid, m_valid);
      check("busy", busy, !m_idle);
      if (m_valid) begin
         check("res_data", res_data, m_data);
         check("res_owner", res_owner, m_owner);
      end
   endtask

   task automatic do_reset();
      rst_n = 1'b0; req_a = 1'b0; req_b = 1'b0; res_ready = 1'b1;
      step();
      step();
      rst_n = 1'b1;
   endtask

   task automatic wait_valid(input string tag);
      int n;
      n = 0;
      while (!res_valid && n < 40) begin
         step();
         n++;
      end
      if (!res_valid) check({tag, "_timeout"}, 1'b0, 1'b1);
   endtask

   // Single job on one channel: checks grant pulse, latency, data and owner, then lets it drain.
   task automatic run_one(input string tag, input bit ch, input int op, input int sh, input int exp);
      int n;
      if (ch) begin req_b = 1'b1; bit4_b = DIN_W'(op); shamt_b = SHAMT_W'(sh); end
      else    begin req_a = 1'b1; bit4_a = DIN_W'(op); shamt_a = SHAMT_W'(sh); end
      n = 0;
      do begin step(); n++; end while (!(gnt_a || gnt_b) && n < 20);
      check({tag, "_gnt"}, ch ? gnt_b : gnt_a, 1'b1);
      req_a = 1'b0; req_b = 1'b0;
      n = 0;
      while (!res_valid && n < 40) begin step(); n++; end
      check({tag, "_lat"}, n, latency(sh));
      check({tag, "_data"}, res_data, exp);
      check({tag, "_owner"}, res_owner, ch);
      step();
   endtask

   initial begin
      bit4_a = '0; bit4_b = '0; shamt_a = '0; shamt_b = '0;
      m_cyc = 0; m_due = 0; m_idle = 1'b1; m_valid = 1'b0; m_last = 1'b1; m_owner = 1'b0; m_data = 0;
      do_reset();
      check("rst_data", res_data, 16'h0000);
      check("rst_owner", res_owner, 1'b0);
      check("rst_busy", busy, 1'b0);

      run_one("a13s4", 1'b0, 13, 4, 16'h00D0);
      run_one("b8s0", 1'b1, 8, 0, 16'h0008);
      run_one("a13s15", 1'b0, 13, 15, 16'h8000);
      run_one("a13s12", 1'b0, 13, 12, 16'hD000);

      // Both held from reset: strict alternation starting with A.
      do_reset();
      req_a = 1'b1; bit4_a = 4'd13; shamt_a = 4'd2;
      req_b = 1'b1; bit4_b = 4'd8;  shamt_b = 4'd3;
      for (int k = 0; k < 4; k++) begin
         wait_valid("tie");
         check("tie_owner", res_owner, k % 2);
         check("tie_data", res_data, (k % 2) ? 16'h0040 : 16'h0034);
         step();
      end
      req_a = 1'b0; req_b = 1'b0;
      while (busy) step();

      // Backpressure: result holds and B is not granted while DONE waits.
      res_ready = 1'b0;
      req_a = 1'b1; bit4_a = 4'd13; shamt_a = 4'd4;
      step();
      req_a = 1'b0;
      req_b = 1'b1; bit4_b = 4'd5; shamt_b = 4'd1;
      wait_valid("bp");
      for (int k = 0; k < 10; k++) begin
         step();
         check("bp_valid", res_valid, 1'b1);
         check("bp_data", res_data, 16'h00D0);
         check("bp_gnt_b", gnt_b, 1'b0);
         check("bp_busy", busy, 1'b1);
      end
      res_ready = 1'b1;
      step();
      check("bp_release_valid", res_valid, 1'b0);
      check("bp_release_busy", busy, 1'b0);
      step();
      check("bp_then_gnt_b", gnt_b, 1'b1);
      req_b = 1'b0;
      for (int k = 0; k < 20 && busy; k++) step();

      // Reset in the middle of a long shift.
      req_a = 1'b1; bit4_a = 4'd13; shamt_a = 4'd10;
      step();
      req_a = 1'b0;
      repeat (3) step();
      rst_n = 1'b0;
      step();
      check("midrst_valid", res_valid, 1'b0);
      check("midrst_data", res_data, 16'h0000);
      check("midrst_owner", res_owner, 1'b0);
      check("midrst_busy", busy, 1'b0);
      check("midrst_gnt", {gnt_a, gnt_b}, 2'b00);
      rst_n = 1'b1;
      req_a = 1'b1; req_b = 1'b1; bit4_a = 4'd3; bit4_b = 4'd7; shamt_a = 4'd1; shamt_b = 4'd2;
      step();
      check("midrst_tie_a", {gnt_a, gnt_b}, 2'b10);
      req_a = 1'b0; req_b = 1'b0;
      for (int k = 0; k < 20 && busy; k++) step();
      res_ready = 1'b1;
      step();

      // Random traffic; requesters hold data until granted and occasionally withdraw.
      for (int i = 0; i < 3000; i++) begin
         if (req_a && gnt_a) req_a = 1'b0;
         else if (req_a && $urandom_range(31) == 0) req_a = 1'b0;
         else if (!req_a && $urandom_range(3) == 0) begin
            req_a = 1'b1; bit4_a = DIN_W'($urandom); shamt_a = SHAMT_W'($urandom);
         end
         if (req_b && gnt_b) req_b = 1'b0;
         else if (req_b && $urandom_range(31) == 0) req_b = 1'b0;
         else if (!req_b && $urandom_range(3) == 0) begin
            req_b = 1'b1; bit4_b = DIN_W'($urandom); shamt_b = SHAMT_W'($urandom);
         end
         res_ready = ($urandom_range(2) != 0);
         step();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/lshift_arbiter.md
Name: lshift_arbiter

Overview:
- Shares one iterative 16-bit left-shift engine between two requesters, channel A and channel B.
- Each channel supplies a 4-bit operand and a 4-bit shift amount.
- A 2-way round-robin arbiter grants one request at a time; the engine shifts one bit per cycle and holds the tagged result until downstream accepts it.
- Sits between the two operand producers and the result consumer in the shifter datapath.

Parameters:
- DIN_W, 4, operand width per requester
- SHAMT_W, 4, shift-amount width (maximum shift 2^SHAMT_W-1)
- DOUT_W, 16, result width; operand is zero-extended to this width

Ports:
- clk  input  1  single system clock, rising edge
- rst_n  input  1  synchronous active-low reset, sampled on rising clk
- req_a  input  1  channel A request; held with data until gnt_a
- bit4_a  input  DIN_W  channel A operand
- shamt_a  input  SHAMT_W  channel A shift amount
- gnt_a  output  1  one-cycle pulse: A's operand captured this cycle
- req_b  input  1  channel B request
- bit4_b  input  DIN_W  channel B operand
- shamt_b  input  SHAMT_W  channel B shift amount
- gnt_b  output  1  one-cycle pulse: B's operand captured this cycle
- res_valid  output  1  result available
- res_data  output  DOUT_W  shifted result
- res_owner  output  1  0 = result belongs to A, 1 = to B
- res_ready  input  1  downstream accepts result when high with res_valid
- busy  output  1  high in any state other than IDLE

Behaviour:
- Clock and reset: one clock, clk; reset is synchronous and active-low, rst_n.
- Reset values (rst_n low at a rising edge): state = IDLE, gnt_a/gnt_b = 0, res_valid = 0, res_data = 0, res_owner = 0, busy = 0, count = 0, last_owner = B (so A wins the first tie).
- Reset mid-operation aborts the current job; the result is lost and no grant is reissued.
- FSM states: IDLE, SHIFT, DONE.
- IDLE, no request: stay in IDLE, all grants 0.
- IDLE, request present (grant is combinational from req and last_owner, registered as a pulse):
  - only one req high: grant that channel
  - both high: grant the channel that is not last_owner
  - on the grant edge: data <= zero-extended operand, count <= shamt, res_owner <= granted channel, last_owner <= granted channel
  - next state is SHIFT if shamt != 0, otherwise DONE
  - gnt_x is high for exactly one cycle, the cycle after capture edge
- SHIFT, each cycle: data <= data << 1, count <= count - 1.
  - Leave for DONE on the edge where count == 1, so exactly shamt shift cycles occur.
  - Bits shifted past bit DOUT_W-1 are discarded; no overflow flag.
- DONE:
  - res_valid = 1; res_data and res_owner are stable.
  - On res_valid && res_ready: res_valid <= 0, next state IDLE.
  - res_ready low: hold indefinitely.
  - New requests are not granted outside IDLE; requesters must keep req and data stable.
- Latency: grant edge to res_valid = shamt + 1 cycles.
- Throughput: one job per shamt + 3 cycles minimum (grant, shifts, DONE, return to IDLE).
- Simultaneous release and request: a request arriving in the same cycle that DONE hands off is arbitrated in IDLE on the next cycle; there is no back-to-back bypass.
- req withdrawn before grant: legal; nothing captured.

Optional Feature:
- Macro: LSHIFT_BARREL_EN.
- Defined: the SHIFT state is removed. On grant, data <= operand << shamt (full barrel shift) and next state is always DONE. Latency is a constant 1 cycle.
- Undefined: the iterative one-bit-per-cycle engine above.
- res_data values are identical in both builds; only timing differs.

Decomposition:
- Package lshift_pkg:
  - state enum {IDLE, SHIFT, DONE}
  - owner constants OWNER_A = 0, OWNER_B = 1
  - default width constants DIN_W, SHAMT_W, DOUT_W
- Sub-module lshift_rr_arb: 2-way round-robin arbiter.
  - Inputs: req_a, req_b, last_owner, enable (state == IDLE).
  - Outputs: one-hot grant, granted owner.
- The shift engine and FSM stay in lshift_arbiter.

Test Plan:
- Reset release, only req_a, bit4_a = 13, shamt_a = 4, res_ready = 1 -> gnt_a pulse; res_valid 5 cycles later; res_data = 16'h00D0; res_owner = 0.
- req_a and req_b both high from reset; A: 13 shift 2, B: 8 shift 3 -> A granted first (res_data = 16'h0034); then B (res_data = 16'h0040, owner = 1); alternation continues while both are held.
- shamt_b = 0, bit4_b = 8 -> DONE one cycle after grant, res_data = 16'h0008.
- Overflow: bit4_a = 13, shamt_a = 15 -> res_data = 16'h8000; shamt_a = 12 -> 16'hD000.
- Backpressure: res_ready low for 10 cycles in DONE -> res_valid and res_data hold, no grants issued, busy = 1; raising res_ready returns to IDLE next edge.
- rst_n low during SHIFT (A, shamt = 10, after 3 shifts) -> next edge all outputs at reset values; a following tie grants A.
- Build with LSHIFT_BARREL_EN and repeat the first scenario -> same data, res_valid 1 cycle after grant.
